// File: rtl/mips_commit_trace.sv
// mips_commit_trace
//
// Retirement-trace buffer for the pipelined MIPS core. Every instruction that
// retires in writeback (and is not flushed) is captured as one entry
// {pc, result, register number, write enable} in a DEPTH-entry FIFO. A debug
// or trace consumer drains the head entry over a valid/ready handshake.
//
// Handshake: the head entry is offered while trace_valid=1. It is consumed on a
// rising clk edge where trace_valid=1 and trace_ready=1. While trace_valid=1 and
// trace_ready=0, every trace_* field holds its value. trace_valid never depends
// on trace_ready.
//
// Full handling:
//   FULL_MODE=0 : a commit that arrives while the FIFO is full and not being
//                 popped is discarded and counted.
//   FULL_MODE=1 : stall_req asks the core to hold writeback while full and the
//                 consumer is not taking an entry. A commit that arrives anyway
//                 is still discarded and counted.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   commitW         an instruction retires in writeback this cycle
//   flushW          writeback flushed, suppresses capture
//   pcW, resultW    pc and writeback value of the retiring instruction
//   writeregW       destination register number
//   regwriteW       register write enable
//   clear           synchronous clear of FIFO and statistics (wins over push/pop)
//   trace_ready     consumer accepts the head entry
//   trace_valid     head entry available
//   trace_pc, trace_wdata, trace_wnum, trace_wen
//                   head entry fields, all zero while trace_valid=0
//   stall_req       core freeze request (constant 0 when FULL_MODE=0)
//   count           current occupancy, 0..DEPTH
//   drop_cnt        number of commits lost, saturating at all-ones
//   overflow        sticky flag, at least one commit lost since reset/clear

module mips_commit_trace #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 8,
  parameter int FULL_MODE = 0,
  parameter int FILTER_R0 = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commitW,
  input  logic                     flushW,
  input  logic [DATA_W-1:0]        pcW,
  input  logic [DATA_W-1:0]        resultW,
  input  logic [REG_W-1:0]         writeregW,
  input  logic                     regwriteW,
  input  logic                     clear,
  input  logic                     trace_ready,
  output logic                     trace_valid,
  output logic [DATA_W-1:0]        trace_pc,
  output logic [DATA_W-1:0]        trace_wdata,
  output logic [REG_W-1:0]         trace_wnum,
  output logic                     trace_wen,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Storage is deliberately not reset; count decides what is meaningful.
  logic [DATA_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [REG_W-1:0]  wnum_mem [DEPTH];
  logic              wen_mem  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              push;
  logic              pop;
  logic              full;
  logic              do_push;
  logic              do_pop;
  logic              drop;
  logic              wen_in;
  logic              r0_write;

  // ---------------------------------------------------------------------------
  // Capture side
  // ---------------------------------------------------------------------------
  assign push     = commitW & ~flushW;
  assign r0_write = (FILTER_R0 != 0) && (writeregW == '0);
  assign wen_in   = regwriteW & ~r0_write;

  assign full     = (count == OCC_W'(DEPTH));
  assign pop      = trace_valid & trace_ready;

  // A pop in the same cycle frees the slot the push lands in, so a full FIFO
  // that is being drained still accepts the new entry. Clear overrides both.
  assign do_pop   = pop & ~clear;
  assign do_push  = push & ~clear & (~full | pop);
  assign drop     = push & ~clear & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= pcW;
      data_mem[wr_ptr] <= resultW;
      wnum_mem[wr_ptr] <= writeregW;
      wen_mem[wr_ptr]  <= wen_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy. DEPTH is a power of two, so the natural wrap of
  // PTR_W-bit pointers is exactly modulo DEPTH.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loss accounting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. Fields are forced to zero when nothing is offered so the
  // consumer never sees stale storage.
  // ---------------------------------------------------------------------------
  assign trace_valid = (count != '0);

  always_comb begin
    trace_pc    = '0;
    trace_wdata = '0;
    trace_wnum  = '0;
    trace_wen   = 1'b0;
    if (trace_valid) begin
      trace_pc    = pc_mem[rd_ptr];
      trace_wdata = data_mem[rd_ptr];
      trace_wnum  = wnum_mem[rd_ptr];
      trace_wen   = wen_mem[rd_ptr];
    end
  end

  // Combinational so the core sees the freeze in the same cycle the consumer
  // stops taking entries; a ready consumer frees a slot, so no stall then.
  assign stall_req = (FULL_MODE != 0) ? (full & ~trace_ready) : 1'b0;

endmodule

// File: tb/tb_mips_commit_trace.sv
// Bench for mips_commit_trace. Two instances share all inputs:
//   dut0 : defaults (drop mode, $0 filter on, 16-bit drop counter)
//   dut1 : stall mode, $0 filter off, 4-bit drop counter (saturates at 15)
// A queue-based reference model predicts both.

module tb_mips_commit_trace;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          commitW;
  logic          flushW;
  logic [DW-1:0] pcW;
  logic [DW-1:0] resultW;
  logic [RW-1:0] writeregW;
  logic          regwriteW;
  logic          clear;
  logic          trace_ready;

  logic          v0, wen0, st0, ov0;
  logic [DW-1:0] pc0, wd0;
  logic [RW-1:0] wn0;
  logic [3:0]    cnt0;
  logic [15:0]   dc0;

  logic          v1, wen1, st1, ov1;
  logic [DW-1:0] pc1, wd1;
  logic [RW-1:0] wn1;
  logic [3:0]    cnt1;
  logic [3:0]    dc1;

  always #5 clk = ~clk;

  mips_commit_trace #(
    .DATA_W(DW), .REG_W(RW), .DEPTH(D), .FULL_MODE(0), .FILTER_R0(1), .CNT_W(16)
  ) dut0 (
    .clk(clk), .rst(rst), .commitW(commitW), .flushW(flushW), .pcW(pcW),
    .resultW(resultW), .writeregW(writeregW), .regwriteW(regwriteW),
    .clear(clear), .trace_ready(trace_ready), .trace_valid(v0),
    .trace_pc(pc0), .trace_wdata(wd0), .trace_wnum(wn0), .trace_wen(wen0),
    .stall_req(st0), .count(cnt0), .drop_cnt(dc0), .overflow(ov0)
  );

  mips_commit_trace #(
    .DATA_W(DW), .REG_W(RW), .DEPTH(D), .FULL_MODE(1), .FILTER_R0(0), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .commitW(commitW), .flushW(flushW), .pcW(pcW),
    .resultW(resultW), .writeregW(writeregW), .regwriteW(regwriteW),
    .clear(clear), .trace_ready(trace_ready), .trace_valid(v1),
    .trace_pc(pc1), .trace_wdata(wd1), .trace_wnum(wn1), .trace_wen(wen1),
    .stall_req(st1), .count(cnt1), .drop_cnt(dc1), .overflow(ov1)
  );

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list of retired instructions plus loss stats.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] res;
    logic [RW-1:0] rn;
    logic          rw;
  } ent_t;

  ent_t mq[$];
  int   drops;
  bit   lost;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    drops = 0;
    lost  = 1'b0;
  endtask

  // Compare both instances with what the model says is visible right now.
  task automatic check_outputs();
    bit   v;
    ent_t h;
    int   sat0;
    int   sat1;
    v = (mq.size() != 0);
    h = '{pc: '0, res: '0, rn: '0, rw: 1'b0};
    if (v) h = mq[0];
    sat0 = (drops > 65535) ? 65535 : drops;
    sat1 = (drops > 15) ? 15 : drops;
    chk("valid0", 64'(v0), 64'(v));
    chk("pc0",    64'(pc0), 64'(h.pc));
    chk("wdata0", 64'(wd0), 64'(h.res));
    chk("wnum0",  64'(wn0), 64'(h.rn));
    chk("wen0",   64'(wen0), 64'(v && h.rw && (h.rn != 0)));
    chk("count0", 64'(cnt0), 64'(mq.size()));
    chk("drop0",  64'(dc0), 64'(sat0));
    chk("ovf0",   64'(ov0), 64'(lost));
    chk("stall0", 64'(st0), 64'(0));
    chk("valid1", 64'(v1), 64'(v));
    chk("pc1",    64'(pc1), 64'(h.pc));
    chk("wdata1", 64'(wd1), 64'(h.res));
    chk("wnum1",  64'(wn1), 64'(h.rn));
    chk("wen1",   64'(wen1), 64'(v && h.rw));
    chk("count1", 64'(cnt1), 64'(mq.size()));
    chk("drop1",  64'(dc1), 64'(sat1));
    chk("ovf1",   64'(ov1), 64'(lost));
    chk("stall1", 64'(st1), 64'((mq.size() == D) && !trace_ready));
  endtask

  // Effect of the coming clock edge on the model.
  task automatic model_step();
    bit pop;
    bit push;
    if (rst || clear) begin
      model_reset();
    end else begin
      pop  = (mq.size() != 0) && trace_ready;
      push = commitW && !flushW;
      if (push && (mq.size() == D) && !pop) begin
        drops++;
        lost = 1'b1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{pc: pcW, res: resultW, rn: writeregW, rw: regwriteW});
      end
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic cycle();
    #4;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit f, input logic [DW-1:0] p,
                       input logic [DW-1:0] r, input logic [RW-1:0] n,
                       input bit w, input bit rdy, input bit clr);
    commitW     = c;
    flushW      = f;
    pcW         = p;
    resultW     = r;
    writeregW   = n;
    regwriteW   = w;
    trace_ready = rdy;
    clear       = clr;
  endtask

  task automatic drive_rand_commit(input bit rdy);
    drive(1'b1, 1'b0, $urandom, $urandom, RW'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), rdy, 1'b0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Basic push, hold while not ready, then release.
    drive(1'b1, 1'b0, 32'hBFC0_0000, 32'h0000_1234, 5'd8, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    trace_ready = 1'b1;
    cycle();
    cycle();

    // Write to $0: filtered on dut0, recorded on dut1.
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0000_FFFF, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    trace_ready = 1'b1;
    cycle();

    // Ten commits into an 8-deep FIFO with no consumer: two drops.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'h1000 + 32'(i * 4), $urandom, RW'($urandom_range(1, 31)),
            1'b1, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    // Full with consumer ready and a commit: both happen, no stall, no drop.
    drive(1'b1, 1'b0, 32'h2000, 32'h5, 5'd3, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle();

    // Flushed commit leaves nothing behind.
    drive(1'b1, 1'b1, 32'h3000, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Reach count=5 with three drops, then clear alongside a commit.
    for (int i = 0; i < 11; i++) begin
      drive_rand_commit(1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b1, 1'b0, 32'h4000, 32'h7, 5'd7, 1'b1, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Random traffic, first biased toward a slow consumer (drops, saturation),
    // then toward a fast one.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), $urandom,
            $urandom, RW'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) : 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 149) == 0));
      cycle();
    end
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), $urandom,
            $urandom, RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
      cycle();
    end

    // Twenty push/pop pairs across pointer wrap, count steady at 1.
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive_rand_commit(1'b1);
      cycle();
    end

    // Build up entries, then reset asynchronously in the middle of a cycle.
    for (int i = 0; i < 5; i++) begin
      drive_rand_commit(1'b0);
      cycle();
    end
    drive(1'b1, 1'b0, $urandom, $urandom, 5'd9, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid0", 64'(v0), 64'(0));
    chk("rst_async_count0", 64'(cnt0), 64'(0));
    chk("rst_async_valid1", 64'(v1), 64'(0));
    chk("rst_async_count1", 64'(cnt1), 64'(0));
    model_reset();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_commit_trace.md
Name: mips_commit_trace

Overview:
- Parametrised retirement-trace buffer for the pipelined MIPS core.
- Captures committed writeback-stage information (pcW, resultW, writeregW, regwriteW) into a DEPTH-entry FIFO.
- Drains entries to a debug/trace consumer over a valid/ready handshake.
- Unlike the fixed single-cycle debug outputs of the core top, it adds buffering, selectable full-handling (drop or stall the core), $0-write filtering and loss accounting.

Parameters:
- DATA_W, 32, width of pc and result fields
- REG_W, 5, width of register-number field
- DEPTH, 8, FIFO entries; power of two, >= 2
- FULL_MODE, 0, 0 = drop new commits when full; 1 = assert stall_req to hold the core
- FILTER_R0, 1, 1 = record writes to register 0 with write-enable forced 0
- CNT_W, 16, width of drop counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- commitW  in  1  an instruction retires in writeback this cycle
- flushW  in  1  writeback stage flushed; suppresses capture
- pcW  in  DATA_W  pc of retiring instruction
- resultW  in  DATA_W  writeback value
- writeregW  in  REG_W  destination register
- regwriteW  in  1  register write enable
- clear  in  1  synchronous clear of FIFO and statistics
- trace_ready  in  1  consumer accepts head entry
- trace_valid  out  1  head entry available
- trace_pc  out  DATA_W  head pc
- trace_wdata  out  DATA_W  head result
- trace_wnum  out  REG_W  head register number
- trace_wen  out  1  head write enable
- stall_req  out  1  request core freeze (FULL_MODE=1 only, else constant 0)
- count  out  $clog2(DEPTH)+1  current occupancy
- drop_cnt  out  CNT_W  commits lost, saturating
- overflow  out  1  sticky: at least one commit lost

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, drop_cnt=0, overflow=0. trace_valid=0, trace_* =0, stall_req=0. Storage array not reset.
- push = commitW & ~flushW. Entry = {pcW, resultW, writeregW, wen}.
  - wen = regwriteW & ~(FILTER_R0 & writeregW==0).
- pop = trace_valid & trace_ready.
- Outputs are driven from storage at rd_ptr. trace_valid = (count!=0). trace_* forced 0 when trace_valid=0.
- Head fields are stable while trace_valid & ~trace_ready.
- Latency: a push in cycle N gives trace_valid=1 in cycle N+1. No same-cycle bypass, even when empty.
- Push and pop in the same cycle:
  - Both are performed and count is unchanged.
  - This holds when full (freed slot reused) and when count=1.
  - When empty, push only.
- Full (count==DEPTH) with push and no pop:
  - Entry discarded; drop_cnt increments, saturating at all-ones.
  - overflow set to 1.
  - Applies in both modes; in mode 1 this is a core protocol violation but is still counted.
- stall_req (FULL_MODE=1) = (count==DEPTH) & ~trace_ready. Combinational. Core holds writeback while it is asserted.
- Pointers are REG_W-independent, $clog2(DEPTH) bits, and wrap modulo DEPTH.
- clear (synchronous, priority over push/pop):
  - Next cycle: pointers=0, count=0, drop_cnt=0, overflow=0.
  - The same-cycle push is discarded and not counted as a drop.
- Reset asserted mid-drain: all state returns to reset values immediately. In-flight entries are lost and no drop is counted.

Test Plan:
- Basic push: reset, one commit pc=0xBFC00000 result=0x1234 reg=8 regwrite=1, trace_ready=0 → next cycle trace_valid=1 with those fields, count=1. Fields hold for 3 cycles. Raise ready → valid=0 next cycle.
- R0 filter: commit reg=0 regwrite=1 result=0xFFFF → entry has trace_wen=0. With FILTER_R0=0 → trace_wen=1.
- Drop mode overflow: DEPTH=8, FULL_MODE=0, ready=0, 10 consecutive commits → count=8, drop_cnt=2, overflow=1. Drain yields the first 8 pcs in order.
- Stall mode: FULL_MODE=1, ready=0, 8 commits → stall_req=1 while count==8. Raise ready with a simultaneous commit → pop and push both performed, count stays 8, stall_req=0 that cycle, drop_cnt=0.
- Flush and clear: commit with flushW=1 → no entry. With count=5, drop_cnt=3, pulse clear together with a commit → next cycle count=0, drop_cnt=0, overflow=0, trace_valid=0.
- Wrap and reset: 20 push/pop pairs with ready=1 → pc order preserved across pointer wrap. Assert rst mid-stream → trace_valid=0 immediately and count=0.
